alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational 8-bit ALU (16-bit result, 4-bit command, tri-state output enable) among NREQ requesters. It accepts one request at a time through a valid/ready handshake, drives the ALU operand and command inputs, asserts the ALU output enable for exactly one cycle, and registers the result. The result is returned with the requester index over a valid/ready response channel. It sits between the requesting engines and the ALU, and it is the only agent that drives the ALU inputs or output enable.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- ID_W, $clog2(NREQ), width of the requester index; derived, never overridden
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; at most one bit high
- req_a  input  NREQ*8  operand A; requester i occupies bits [8i+7:8i]
- req_b  input  NREQ*8  operand B; same packing as req_a
- req_cmd  input  NREQ*4  ALU command; requester i occupies bits [4i+3:4i]
- rsp_valid  output  1  result valid
- rsp_ready  input  1  result consumer ready
- rsp_id  output  ID_W  index of the requester that owns rsp_data
- rsp_data  output  16  captured ALU result
- rsp_err  output  1  divide-by-zero flag; only under the guard macro, otherwise tied 0
- alu_a  output  8  ALU operand A
- alu_b  output  8  ALU operand B
- alu_cmd  output  4  ALU command
- alu_oe  output  1  ALU output enable
- alu_dout  input  16  ALU result bus; high-Z while alu_oe is low

## Operation
- FSM states are IDLE, EXEC and RESP. Reset enters IDLE.
- **IDLE**
  - Grant g is the first index at or after rr_ptr, wrapping modulo NREQ, whose req_valid is high.
  - req_ready[g] is driven combinationally high in IDLE only. All other bits are 0.
  - When req_valid[g] and req_ready[g] are both high: latch the requester's a, b and cmd into alu_a, alu_b and alu_cmd; latch g as the owner; set rr_ptr to (g+1) mod NREQ; go to EXEC.
  - With no valid request, stay in IDLE and leave rr_ptr unchanged.
- **EXEC** (exactly one cycle)
  - Assert alu_oe.
  - At the closing edge: rsp_data is set to alu_dout, rsp_id is set to the owner, and the FSM goes to RESP.
  - alu_oe is registered: it is high only while in EXEC.
- **RESP**
  - Assert rsp_valid.
  - rsp_data, rsp_id and rsp_err stay stable until rsp_valid and rsp_ready are both high.
  - On that handshake: rsp_valid drops and the FSM returns to IDLE.
- rsp_data is not modified by the arbiter. Any wrap, truncation or zero-extension is whatever the ALU produces.
- Requesters must hold req_a, req_b and req_cmd stable while req_valid is high. Requests are never reordered or dropped, except by reset.
- alu_a, alu_b and alu_cmd keep the last issued value outside EXEC.

## Timing
- Reset values: alu_a=0, alu_b=0, alu_cmd=0, alu_oe=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, rr_ptr=0, state=IDLE.
- After reset, req_ready follows the IDLE grant logic combinationally.
- Latency: request accepted at edge N; alu_oe high during cycle N..N+1; rsp_valid high from edge N+2.
- Peak throughput is one operation per 3 cycles, with rsp_ready held high.
- Backpressure: while in RESP, no request is accepted and all req_ready bits are 0.
- Simultaneous requests: only the granted requester is accepted. Others wait and are served in rotating order, so each valid requester waits at most NREQ-1 grants (no starvation).
- rr_ptr wrap: a grant of NREQ-1 sets rr_ptr to 0.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is produced, and all outputs take their reset values immediately.

## Configuration
- **Macro ALU_ARB_DIVZ_GUARD_EN defined:**
  - A granted request with cmd=4'b0101 (divide) and b=0 is not issued to the ALU.
  - The FSM skips EXEC (alu_oe stays 0) and goes IDLE -> RESP.
  - In that RESP: rsp_data=16'hFFFF and rsp_err=1. Latency is 1 cycle.
  - rsp_err is 0 for every other response.
- **Macro not defined:**
  - Divide-by-zero is issued like any other command and rsp_data is whatever the ALU drives.
  - rsp_err is constant 0.

## Test plan
- Reset, then requester 2 issues ADD a=8'h7F b=8'h01 -> one-cycle alu_oe pulse; rsp_valid 2 cycles after accept; rsp_id=2; rsp_data=16'h0080.
- All 4 requesters hold valid from reset, rsp_ready=1 -> grant order 0,1,2,3,0; one response every 3 cycles.
- MUL a=8'hFF b=8'hFF with rsp_ready low for 5 cycles -> rsp_data=16'hFE01 held stable; all req_ready bits 0 throughout; IDLE reached one cycle after rsp_ready rises.
- rst_n pulsed low during EXEC of SUB 5-3 -> alu_oe and rsp_valid drop immediately; no response is emitted; next grant starts from requester 0.
- With ALU_ARB_DIVZ_GUARD_EN: DIV a=8'h10 b=0 -> alu_oe never high; rsp_data=16'hFFFF and rsp_err=1, 1 cycle after accept. Without the macro: DIV a=8'h10 b=8'h04 -> rsp_data=16'h0004 and rsp_err=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter and sequencer sharing one ALU among NREQ requesters
// Optional divide-by-zero guard enabled by defining ALU_ARB_DIVZ_GUARD_EN
module alu_arbiter #(
    parameter int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*8-1:0]   req_a,
    input  logic [NREQ*8-1:0]   req_b,
    input  logic [NREQ*4-1:0]   req_cmd,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [15:0]         rsp_data,
    output logic                rsp_err,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [3:0]          alu_cmd,
    output logic                alu_oe,
    input  logic [15:0]         alu_dout
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] grant;
    logic            grant_found;
    logic [7:0]      grant_a;
    logic [7:0]      grant_b;
    logic [3:0]      grant_cmd;
    logic            accept;
    logic            divz;
    logic [ID_W:0]   scan;

    // Search starts at rr_ptr and wraps, so the last-served requester goes to the back.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        scan        = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NREQ))
                scan = scan - (ID_W+1)'(NREQ);
            if (!grant_found && req_valid[scan[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant       = scan[ID_W-1:0];
            end
        end
    end

    assign grant_a   = req_a[{grant, 3'b000} +: 8];
    assign grant_b   = req_b[{grant, 3'b000} +: 8];
    assign grant_cmd = req_cmd[{grant, 2'b00} +: 4];
    assign accept    = (state == IDLE) && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[grant] = 1'b1;
    end

`ifdef ALU_ARB_DIVZ_GUARD_EN
    assign divz = (grant_cmd == 4'b0101) && (grant_b == 8'h00);
`else
    assign divz = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = divz ? RESP : EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            owner     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cmd   <= '0;
            alu_oe    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            alu_oe    <= (state_next == EXEC);
            rsp_valid <= (state_next == RESP);
            if (accept) begin
                owner  <= grant;
                rr_ptr <= (grant == ID_W'(NREQ-1)) ? '0 : grant + 1'b1;
                if (!divz) begin
                    alu_a   <= grant_a;
                    alu_b   <= grant_b;
                    alu_cmd <= grant_cmd;
                end else begin
                    rsp_data <= 16'hFFFF;
                    rsp_id   <= grant;
                end
            end
            if (state == EXEC) begin
                rsp_data <= alu_dout;
                rsp_id   <= owner;
            end
        end
    end

`ifdef ALU_ARB_DIVZ_GUARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_err <= 1'b0;
        else if (state == EXEC)
            rsp_err <= 1'b0;
        else if (accept && divz)
            rsp_err <= 1'b1;
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ*4-1:0] req_cmd;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [15:0]       rsp_data;
    logic              rsp_err;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [3:0]        alu_cmd;
    logic              alu_oe;
    logic [15:0]       alu_dout;
    logic [15:0]       alu_res;

    int n_assert = 0;
    int n_fail   = 0;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
        .alu_oe(alu_oe), .alu_dout(alu_dout)
    );

    // ALU: 0 ADD, 1 SUB, 2 MUL, 5 DIV
    always_comb begin
        alu_res = 16'h0000;
        case (alu_cmd)
            4'h0: alu_res = {8'h00, alu_a} + {8'h00, alu_b};
            4'h1: alu_res = {8'h00, alu_a} - {8'h00, alu_b};
            4'h2: alu_res = {8'h00, alu_a} * {8'h00, alu_b};
            4'h5: alu_res = (alu_b == 8'h00) ? 16'h0BAD : {8'h00, alu_a / alu_b};
            default: alu_res = 16'h0000;
        endcase
    end
    assign alu_dout = alu_oe ? alu_res : 16'hzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
        req_a[i*8 +: 8]   = a;
        req_b[i*8 +: 8]   = b;
        req_cmd[i*4 +: 4] = c;
    endtask

    logic [1:0]  exp_id   [5];
    logic [15:0] exp_data [5];

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_cmd = '0;
        step(); step();
        chk("rst_alu_a", 32'(alu_a), 32'h0);
        chk("rst_alu_b", 32'(alu_b), 32'h0);
        chk("rst_alu_cmd", 32'(alu_cmd), 32'h0);
        chk("rst_alu_oe", 32'(alu_oe), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;

        // single ADD from requester 2
        set_req(2, 8'h7F, 8'h01, 4'h0);
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        chk("t1_oe", 32'(alu_oe), 32'h1);
        chk("t1_a", 32'(alu_a), 32'h7F);
        chk("t1_b", 32'(alu_b), 32'h01);
        chk("t1_valid_early", 32'(rsp_valid), 32'h0);
        step();
        chk("t1_oe_off", 32'(alu_oe), 32'h0);
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_id", 32'(rsp_id), 32'h2);
        chk("t1_data", 32'(rsp_data), 32'h0080);
        chk("t1_err", 32'(rsp_err), 32'h0);
        rsp_ready = 1'b1;
        step();
        chk("t1_done", 32'(rsp_valid), 32'h0);

        // all requesters valid from reset: rotating grants, one response per 3 cycles
        rst_n = 1'b0;
        set_req(0, 8'h01, 8'h02, 4'h0);
        set_req(1, 8'h11, 8'h02, 4'h1);
        set_req(2, 8'h21, 8'h02, 4'h2);
        set_req(3, 8'h31, 8'h02, 4'h0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_data = '{16'h0003, 16'h000F, 16'h0042, 16'h0033, 16'h0003};
        step();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(4'b0001 << exp_id[k]));
            step();
            chk($sformatf("rr%0d_oe", k), 32'(alu_oe), 32'h1);
            step();
            chk($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(exp_id[k]));
            chk($sformatf("rr%0d_data", k), 32'(rsp_data), 32'(exp_data[k]));
            step();
        end
        req_valid = '0;

        // MUL with 5 cycles of backpressure; requester 3 waits
        set_req(1, 8'hFF, 8'hFF, 4'h2);
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("bp_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b1000;
        chk("bp_oe", 32'(alu_oe), 32'h1);
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d_data", k), 32'(rsp_data), 32'hFE01);
            chk($sformatf("bp%0d_id", k), 32'(rsp_id), 32'h1);
            chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_idle_valid", 32'(rsp_valid), 32'h0);
        chk("bp_idle_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        step();
        chk("bp_r3_id", 32'(rsp_id), 32'h3);
        chk("bp_r3_data", 32'(rsp_data), 32'h0033);
        step();

        // reset during EXEC of SUB 5-3
        set_req(2, 8'h05, 8'h03, 4'h1);
        req_valid = 4'b0100;
        #1;
        chk("rx_ready", 32'(req_ready), 32'b0100);
        step();
        chk("rx_oe", 32'(alu_oe), 32'h1);
        #2;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("rx_oe_drop", 32'(alu_oe), 32'h0);
        chk("rx_valid_drop", 32'(rsp_valid), 32'h0);
        chk("rx_alu_a", 32'(alu_a), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("rx_no_rsp", 32'(rsp_valid), 32'h0);
        step();
        chk("rx_no_rsp2", 32'(rsp_valid), 32'h0);
        set_req(0, 8'h01, 8'h02, 4'h0);
        req_valid = 4'b1001;
        #1;
        chk("rx_ptr0", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        step();
        chk("rx_r0_id", 32'(rsp_id), 32'h0);
        chk("rx_r0_data", 32'(rsp_data), 32'h0003);
        step();

`ifdef ALU_ARB_DIVZ_GUARD_EN
        set_req(1, 8'h10, 8'h00, 4'h5);
        req_valid = 4'b0010;
        #1;
        chk("dz_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        chk("dz_oe", 32'(alu_oe), 32'h0);
        chk("dz_valid", 32'(rsp_valid), 32'h1);
        chk("dz_data", 32'(rsp_data), 32'hFFFF);
        chk("dz_err", 32'(rsp_err), 32'h1);
        chk("dz_id", 32'(rsp_id), 32'h1);
        chk("dz_alu_a_kept", 32'(alu_a), 32'h01);
        step();
        chk("dz_done", 32'(rsp_valid), 32'h0);
`endif
        set_req(1, 8'h10, 8'h04, 4'h5);
        req_valid = 4'b0010;
        #1;
        chk("div_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        chk("div_oe", 32'(alu_oe), 32'h1);
        step();
        chk("div_valid", 32'(rsp_valid), 32'h1);
        chk("div_data", 32'(rsp_data), 32'h0004);
        chk("div_err", 32'(rsp_err), 32'h0);
        chk("div_id", 32'(rsp_id), 32'h1);
        step();
        chk("div_done", 32'(rsp_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
